// File: rtl/spi_seq.sv
// spi_seq: sequences N-byte SPI transfers through the spi_ctrl engine, moving bytes
// between valid/ready TX/RX streams and the engine's 16-bit control/data word.
module spi_seq #(
    parameter int         LEN_W    = 10,
    parameter logic [7:0] FILL     = 8'hFF,
    parameter int         WAIT_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [3:0]       cmd_div,
    input  logic [1:0]       cmd_mode,
    input  logic             cmd_keep_cs,
    input  logic             abort,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      spi_datain,
    output logic             spi_wrh_n,
    input  logic [15:0]      spi_dataout
);
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CSUP, LOAD, STRB, WRISE, WFALL, CAP, FIN} state_t;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [3:0]       div;
    logic [1:0]       mode;
    logic             keep, cs_q, abort_pend;
    logic [7:0]       tx_byte;
    logic [WW-1:0]    wait_cnt;
    logic             rx_only, tx_only, eng_busy, load_go, in_flight;
    logic             unused_dataout;

    assign rx_only        = mode == 2'b10;
    assign tx_only        = mode == 2'b01;
    assign eng_busy       = spi_dataout[7];
    assign in_flight      = state == STRB || state == WRISE || state == WFALL || state == CAP;
    assign load_go        = (rx_only || tx_valid) && (!rx_valid || rx_ready || tx_only);
    assign spi_datain     = {tx_byte, 2'b00, cs_q, cs_q, div};
    assign unused_dataout = ^spi_dataout[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            div        <= '0;
            mode       <= '0;
            keep       <= 1'b0;
            cs_q       <= 1'b0;
            abort_pend <= 1'b0;
            tx_byte    <= '0;
            wait_cnt   <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            tx_ready   <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            spi_wrh_n  <= 1'b1;
        end else begin
            tx_ready  <= 1'b0;
            done      <= 1'b0;
            spi_wrh_n <= 1'b1;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            // once a byte is handed to the engine it must complete; abort only takes effect at CAP
            if (abort && in_flight) begin
                abort_pend <= 1'b1;
                err        <= 1'b1;
            end
            case (state)
                IDLE: if (cmd_valid) begin
                    cnt        <= cmd_len;
                    div        <= cmd_div;
                    mode       <= cmd_mode;
                    keep       <= cmd_keep_cs;
                    err        <= 1'b0;
                    abort_pend <= 1'b0;
                    cs_q       <= 1'b1;
                    cmd_ready  <= 1'b0;
                    busy       <= 1'b1;
                    state      <= CSUP;
                end
                CSUP: begin
                    err   <= err | abort;
                    state <= abort ? FIN : LOAD;
                end
                LOAD: if (abort) begin
                    err   <= 1'b1;
                    state <= FIN;
                end else if (load_go) begin
                    tx_byte   <= rx_only ? FILL : tx_data;
                    tx_ready  <= !rx_only;
                    spi_wrh_n <= 1'b0;
                    state     <= STRB;
                end
                STRB: begin
                    wait_cnt <= '0;
                    state    <= WRISE;
                end
                WRISE: if (eng_busy) begin
                    state <= WFALL;
                end else if (wait_cnt == WW'(WAIT_MAX - 1)) begin
                    err   <= 1'b1;
                    state <= FIN;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                WFALL: if (!eng_busy) state <= CAP;
                CAP: begin
                    if (!tx_only) begin
                        rx_data  <= spi_dataout[15:8];
                        rx_valid <= 1'b1;
                    end
                    if (cnt == '0 || abort_pend || abort) begin
                        state <= FIN;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= LOAD;
                    end
                end
                FIN: begin
                    cs_q       <= keep & ~err;
                    abort_pend <= 1'b0;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    cmd_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_seq.sv
// tb_spi_seq: drives spi_seq against a loopback engine model and a queue-based
// reference of the bytes each command must move.
module tb_spi_seq;
    localparam logic [7:0] FILL = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_keep_cs, abort;
    logic [9:0]  cmd_len;
    logic [3:0]  cmd_div;
    logic [1:0]  cmd_mode;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0]  tx_data, rx_data;
    logic        busy, done, err, spi_wrh_n;
    logic [15:0] spi_datain, spi_dataout;

    spi_seq #(.LEN_W(10), .FILL(FILL), .WAIT_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_div(cmd_div), .cmd_mode(cmd_mode), .cmd_keep_cs(cmd_keep_cs),
        .abort(abort), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .busy(busy),
        .done(done), .err(err), .spi_datain(spi_datain), .spi_wrh_n(spi_wrh_n),
        .spi_dataout(spi_dataout)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, wrh_cnt = 0, txr_cnt = 0, done_cnt = 0, e_strobes = 0, wrh_cyc = 0, done_cyc = 0;
    logic prev_wrh = 1'b1, prev_ebusy = 1'b0, cs_drop = 1'b0, strobe_en = 1'b1, rx_hold = 1'b0;
    logic [7:0] tx_q[$], exp_mosi[$], exp_rx[$], rx_log[$], pat[$];

    // engine model: loopback, busy for (div+1)*4 cycles after a strobe
    logic       e_busy;
    logic [7:0] eshift, e_rx;
    logic [3:0] ediv;
    int         ecnt;
    assign spi_dataout = {e_rx, e_busy, 7'd0};
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_busy <= 1'b0;
            e_rx   <= 8'h00;
            eshift <= 8'h00;
            ediv   <= 4'h0;
            ecnt   <= 0;
        end else if (e_busy) begin
            if (ecnt <= 1) begin
                e_busy <= 1'b0;
                e_rx   <= eshift;
            end else ecnt <= ecnt - 1;
        end else if (!spi_wrh_n && strobe_en) begin
            e_busy <= 1'b1;
            eshift <= spi_datain[15:8];
            ediv   <= spi_datain[3:0];
            ecnt   <= (int'(spi_datain[3:0]) + 1) * 4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // compare process: protocol invariants and scoreboard every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            chk("busy_eq_not_ready", busy, !cmd_ready);
            if (!spi_wrh_n) begin
                wrh_cnt++;
                wrh_cyc = cyc;
                chk("wrh_one_cycle", prev_wrh, 1);
                chk("wrh_engine_idle", e_busy, 0);
                chk("cs_en_on_strobe", spi_datain[5:4], 2'b11);
            end
            if (e_busy && !prev_ebusy) begin
                e_strobes++;
                chk("mosi_expected", exp_mosi.size() != 0, 1);
                if (exp_mosi.size() != 0) chk("mosi_byte", eshift, exp_mosi.pop_front());
            end
            if (e_busy) begin
                chk("datain_stable", spi_datain[15:8], eshift);
                chk("div_stable", spi_datain[3:0], ediv);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!spi_datain[4]) cs_drop = 1'b1;
            if (tx_ready) begin
                txr_cnt++;
                if (tx_q.size() != 0) void'(tx_q.pop_front());
            end
            rx_ready = !rx_hold && $urandom_range(0, 3) != 0;
            if (rx_valid && rx_ready) begin
                rx_log.push_back(rx_data);
                chk("rx_expected", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) chk("rx_byte", rx_data, exp_rx.pop_front());
            end
            tx_valid = tx_q.size() != 0 && $urandom_range(0, 3) != 0;
            tx_data  = tx_q.size() != 0 ? tx_q[0] : 8'h00;
        end
        prev_wrh   = spi_wrh_n;
        prev_ebusy = e_busy;
    end

    task automatic start_cmd(input int len, input int dv, input logic [1:0] md, input logic keep,
                             input int nsent);
        logic [7:0] b, mb;
        for (int i = 0; i <= len; i++) begin
            b = pat.size() != 0 ? pat.pop_front() : 8'($urandom);
            if (md != 2'b10) tx_q.push_back(b);
            if (i < nsent) begin
                mb = md == 2'b10 ? FILL : b;
                exp_mosi.push_back(mb);
                if (md != 2'b01) exp_rx.push_back(mb);
            end
        end
        wrh_cnt = 0; txr_cnt = 0; done_cnt = 0; e_strobes = 0;
        rx_log.delete();
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_len = 10'(len); cmd_div = 4'(dv); cmd_mode = md; cmd_keep_cs = keep;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("err_cleared_on_accept", err, 0);
    endtask

    task automatic finish_cmd(input string tag, input int exp_wrh, input int exp_txr,
                              input logic exp_err, input logic exp_cs, input int tx_left);
        int t = 0;
        while (done_cnt == 0 && t < 5000) begin @(posedge clk); #1; t++; end
        t = 0;
        while ((rx_valid || exp_rx.size() != 0) && t < 2000) begin @(posedge clk); #1; t++; end
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_cs"}, spi_datain[5:4], {exp_cs, exp_cs});
        chk({tag, "_wrh_pulses"}, wrh_cnt, exp_wrh);
        chk({tag, "_tx_ready_pulses"}, txr_cnt, exp_txr);
        chk({tag, "_mosi_left"}, exp_mosi.size(), 0);
        chk({tag, "_rx_left"}, exp_rx.size(), 0);
        chk({tag, "_tx_left"}, tx_q.size(), tx_left);
        chk({tag, "_idle"}, busy, 0);
        tx_q.delete();
    endtask

    int         len, dv, t;
    logic [1:0] md;
    logic       kp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_div = '0; cmd_mode = '0;
        cmd_keep_cs = 1'b0; abort = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_datain", spi_datain, 16'h0000);
        chk("rst_wrh_n", spi_wrh_n, 1);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pat = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        start_cmd(3, 0, 2'b00, 1'b0, 4);
        finish_cmd("t1", 4, 4, 1'b0, 1'b0, 0);
        chk("t1_rx_count", rx_log.size(), 4);
        if (rx_log.size() == 4) begin
            chk("t1_rx0", rx_log[0], 8'hA5);
            chk("t1_rx1", rx_log[1], 8'h3C);
            chk("t1_rx2", rx_log[2], 8'hFF);
            chk("t1_rx3", rx_log[3], 8'h00);
        end

        start_cmd(1, 2, 2'b10, 1'b0, 2);
        finish_cmd("t2", 2, 0, 1'b0, 1'b0, 0);
        chk("t2_rx_count", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            chk("t2_rx0", rx_log[0], 8'hFF);
            chk("t2_rx1", rx_log[1], 8'hFF);
        end

        rx_hold = 1'b1;
        pat = '{8'h11, 8'h22, 8'h33};
        start_cmd(2, 0, 2'b00, 1'b0, 3);
        repeat (80) @(posedge clk);
        #1;
        chk("t3_stalled_wrh", wrh_cnt, 1);
        chk("t3_held_valid", rx_valid, 1);
        chk("t3_held_data", rx_data, 8'h11);
        chk("t3_still_busy", busy, 1);
        rx_hold = 1'b0;
        finish_cmd("t3", 3, 3, 1'b0, 1'b0, 0);

        start_cmd(0, 1, 2'b00, 1'b1, 1);
        finish_cmd("t4a", 1, 1, 1'b0, 1'b1, 0);
        cs_drop = 1'b0;
        start_cmd(0, 1, 2'b00, 1'b1, 1);
        finish_cmd("t4b", 1, 1, 1'b0, 1'b1, 0);
        chk("t4_cs_held", cs_drop, 0);
        start_cmd(0, 1, 2'b00, 1'b0, 1);
        finish_cmd("t4c", 1, 1, 1'b0, 1'b0, 0);

        start_cmd(3, 1, 2'b00, 1'b1, 2);
        t = 0;
        while (!(e_strobes == 2 && e_busy) && t < 2000) begin @(posedge clk); #1; t++; end
        chk("t5_reached_byte1", e_strobes == 2 && e_busy, 1);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        finish_cmd("t5", 2, 2, 1'b1, 1'b0, 2);
        chk("t5_rx_count", rx_log.size(), 2);

        strobe_en = 1'b0;
        start_cmd(0, 0, 2'b00, 1'b1, 0);
        finish_cmd("t6", 1, 1, 1'b1, 1'b0, 0);
        chk("t6_timeout_latency", done_cyc - wrh_cyc, 5);
        strobe_en = 1'b1;

        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(0, 6);
            dv  = $urandom_range(0, 3);
            md  = 2'($urandom);
            kp  = 1'($urandom);
            start_cmd(len, dv, md, kp, len + 1);
            finish_cmd("rnd", len + 1, md == 2'b10 ? 0 : len + 1, 1'b0, kp, 0);
        end

        start_cmd(3, 2, 2'b00, 1'b1, 4);
        t = 0;
        while (!e_busy && t < 2000) begin @(posedge clk); #1; t++; end
        chk("rst_mid_reached", e_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_datain", spi_datain, 16'h0000);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        @(posedge clk); #1;
        tx_q.delete(); exp_mosi.delete(); exp_rx.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_cmd(2, 0, 2'b01, 1'b0, 3);
        finish_cmd("post_rst", 3, 3, 1'b0, 1'b0, 0);
        chk("post_rst_no_rx", rx_log.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
